data_memory_bus: RTL

DATA_MEMORY_BUS -- requirements
Module: data_memory_bus

---
 rtl/data_memory_bus.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_bus.sv
// -----------------------------------------------------------------------------
// data_memory_bus
//
// Byte-addressed, little-endian data memory behind a simple request/response
// bus. One access is in flight at a time. A request is accepted on a rising
// edge where req_i and ready_o are both high. The store commits, or the load
// data is captured, LATENCY edges later. valid_o then pulses for one cycle
// with the result.
//
// Parameters
//   DEPTH_BYTES  memory size in bytes (power of two, multiple of 4, >= 8)
//   LATENCY      edges from acceptance to commit/response (>= 1)
//
// Ports
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous active-high reset (memory contents are kept)
//   req_i       request valid
//   we_i        1 = store, 0 = load
//   size_i      00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i  load extension: 1 = zero-extend, 0 = sign-extend
//   addr_i      byte address
//   data_i      store data, right-aligned
//   ready_o     request accepted this cycle when req_i is also high
//   valid_o     one-cycle response strobe
//   data_o      load result (0 for stores, errors and when valid_o is low)
//   err_o       access rejected (misaligned, illegal size, out of range)
//
// Optional feature
//   DMEM_RANGE_CHECK_EN  when defined, any access that reaches at or beyond
//                        DEPTH_BYTES is rejected. Otherwise the address is
//                        taken modulo DEPTH_BYTES.
// -----------------------------------------------------------------------------
module data_memory_bus #(
   parameter int DEPTH_BYTES = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic        err_o
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          commit;
   logic          bad;

   logic          we_p0;
   logic [1:0]    size_p0;
   logic          uns_p0;
   logic [31:0]   addr_p0;
   logic [31:0]   data_p0;

   logic [AW-1:0] idx;
   logic [31:0]   raw;

   logic [7:0]    mem [DEPTH_BYTES] = '{default: 8'h00};

   // Byte/half loads are extended to 32 bits; word loads pass through.
   function automatic logic [31:0] extend(input logic [1:0]  size,
                                          input logic        uns,
                                          input logic [31:0] word);
      logic [31:0] res;
      case (size)
         2'b00:   res = uns ? {24'h0, word[7:0]}  : {{24{word[7]}},  word[7:0]};
         2'b01:   res = uns ? {16'h0, word[15:0]} : {{16{word[15]}}, word[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   assign ready_o = (state != BUSY);
   assign accept  = req_i && ready_o;

   // Stage p0: request captured at the accept edge, held until commit.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         we_p0   <= we_i;
         size_p0 <= size_i;
         uns_p0  <= unsigned_i;
         addr_p0 <= addr_i;
         data_p0 <= data_i;
      end
   end

   assign idx = addr_p0[AW-1:0];

   // Aligned accesses never wrap inside the word, so the upper two bytes of
   // raw are simply ignored for narrow loads near the top of memory.
   assign raw = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};

   always_comb begin
      bad = 1'b0;
      case (size_p0)
         2'b00:   bad = 1'b0;
         2'b01:   bad = addr_p0[0];
         2'b10:   bad = |addr_p0[1:0];
         default: bad = 1'b1;
      endcase
`ifdef DMEM_RANGE_CHECK_EN
      // Last byte touched = addr + size_bytes - 1, evaluated without overflow.
      if (({1'b0, addr_p0} + {31'h0, (size_p0 == 2'b10) ? 2'd3 : {1'b0, size_p0[0]}})
          >= 33'(DEPTH_BYTES))
         bad = 1'b1;
`endif
   end

`ifndef DMEM_RANGE_CHECK_EN
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_p0[31:AW];
`endif

   // The edge that leaves RESP is edge T+LATENCY: commit/capture happens here
   // unless reset is asserted at that same edge.
   assign commit = !rst_i && (state == RESP) && !bad;

   always_ff @(posedge clk_i) begin
      if (commit && we_p0) begin
         case (size_p0)
            2'b00: mem[idx] <= data_p0[7:0];
            2'b01: begin
               mem[idx]          <= data_p0[7:0];
               mem[idx + AW'(1)] <= data_p0[15:8];
            end
            2'b10: begin
               mem[idx]          <= data_p0[7:0];
               mem[idx + AW'(1)] <= data_p0[15:8];
               mem[idx + AW'(2)] <= data_p0[23:16];
               mem[idx + AW'(3)] <= data_p0[31:24];
            end
            default: ;
         endcase
      end
   end

   // Stage p1: control FSM and registered response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         valid_o <= 1'b0;
         err_o   <= 1'b0;
         data_o  <= '0;
      end else begin
         valid_o <= (state == RESP);
         err_o   <= (state == RESP) && bad;
         data_o  <= (commit && !we_p0) ? extend(size_p0, uns_p0, raw) : 32'h0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  state <= (LATENCY == 1) ? RESP : BUSY;
                  cnt   <= CNT_LOAD;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (cnt == '0) state <= RESP;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
